mem_req_queue: RTL and testbench

Parametrised pre-memory stage that succeeds the single-request pre-MEM stage. It sits between EXE and MEM and adds support for up to OUTSTANDING in-flight data requests. It checks alignment, issues sized and strobed data-bus requests, and keeps all operations in order in a completion queue. It returns aligned, sign/zero-extended results to MEM in program order and drains stale responses after a pipeline flush.

---
 rtl/mem_req_queue.sv | 264 ++++++++++++++++++++++++++
 tb/tb_mem_req_queue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_queue.sv
// mem_req_queue: pre-memory stage between EXE and MEM with up to OUTSTANDING in-flight data
// requests. It checks alignment, issues sized and strobed bus requests, and keeps every op
// in a program-order completion queue (Q). Read data returns through a response FIFO (R) and
// is aligned and extended before it goes to MEM. After a flush, responses to requests that
// were already accepted by the bus ("ghosts") are counted and dropped.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   flush                pipeline flush; clears S, Q and R on the next edge
//   in_*                 EXE-side op (valid/ready handshake)
//   req*                 data-bus request channel (held stable until req_addr_ok)
//   rsp_data_ok/rdata    in-order bus responses for reads and writes
//   out_*                MEM-side result (valid/ready handshake)
//   inflight             live issued-unresponded requests plus ghosts
module mem_req_queue #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned OUTSTANDING = 4,
   parameter int unsigned DEST_W      = 5
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic                           in_load,
   input  logic                           in_store,
   input  logic [1:0]                     in_size,
   input  logic                           in_sign,
   input  logic [31:0]                    in_addr,
   input  logic [DATA_W-1:0]              in_wdata,
   input  logic [DEST_W-1:0]              in_dest,
   input  logic                           in_ex,
   input  logic [4:0]                     in_exccode,
   input  logic [31:0]                    in_badvaddr,
   output logic                           req,
   output logic                           req_wr,
   output logic [2:0]                     req_size,
   output logic [31:0]                    req_addr,
   output logic [DATA_W/8-1:0]            req_wstrb,
   output logic [DATA_W-1:0]              req_wdata,
   input  logic                           req_addr_ok,
   input  logic                           rsp_data_ok,
   input  logic [DATA_W-1:0]              rsp_rdata,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [DEST_W-1:0]              out_dest,
   output logic [DATA_W-1:0]              out_data,
   output logic                           out_ex,
   output logic [4:0]                     out_exccode,
   output logic [31:0]                    out_badvaddr,
   output logic [$clog2(OUTSTANDING):0]   inflight
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OFF_W  = $clog2(STRB_W);
   localparam int unsigned PW     = $clog2(OUTSTANDING);
   localparam int unsigned CW     = PW + 1;

   typedef struct packed {
      logic              need_rsp;
      logic              load;
      logic [1:0]        size;
      logic              sign;
      logic [OFF_W-1:0]  off;
      logic [DEST_W-1:0] dest;
      logic [DATA_W-1:0] data;
      logic              ex;
      logic [4:0]        exccode;
      logic [31:0]       badvaddr;
   } q_entry_t;

   // Stage register S
   logic              s_valid;
   logic              s_load;
   logic              s_store;
   logic [1:0]        s_size;
   logic              s_sign;
   logic [31:0]       s_addr;
   logic [DATA_W-1:0] s_wdata;
   logic [DEST_W-1:0] s_dest;
   logic              s_ex;
   logic [4:0]        s_exccode;
   logic [31:0]       s_badvaddr;

   // Completion queue Q and response FIFO R; pointers carry an extra wrap bit
   q_entry_t          q_mem [OUTSTANDING];
   logic [PW:0]       q_wr, q_rd;
   logic [DATA_W-1:0] r_mem [OUTSTANDING];
   logic [PW:0]       r_wr, r_rd;

   logic [CW-1:0]     live_cnt, ghost_cnt;

   logic              s_mem, s_misal, f_ex;
   logic [4:0]        f_code;
   logic [31:0]       f_badv;
   logic [2:0]        amask;
   logic [STRB_W-1:0] strb_base;
   logic [OFF_W-1:0]  s_off;
   logic              q_full, q_empty, r_empty, q_space;
   logic              q_push, q_pop, r_push, r_pop;
   logic              accept, s_leave, s_take, drop, live_rsp;
   q_entry_t          q_in, q_head;
   logic [DATA_W-1:0] r_head, sh, keep, ext;
   logic              sbit;

   always_comb begin
      s_mem = s_load | s_store;
      s_off = s_addr[OFF_W-1:0];

      unique case (s_size)
         2'd0:    amask = 3'b000;
         2'd1:    amask = 3'b001;
         2'd2:    amask = 3'b011;
         default: amask = 3'b111;
      endcase
      s_misal = (s_addr[2:0] & amask) != 3'b000;

      // Upstream exception wins over the local alignment fault
      f_ex   = s_ex | (s_mem & s_misal);
      f_code = s_ex ? s_exccode : (s_load ? 5'd4 : 5'd5);
      f_badv = s_ex ? s_badvaddr : s_addr;

      q_full  = (q_wr[PW] != q_rd[PW]) && (q_wr[PW-1:0] == q_rd[PW-1:0]);
      q_empty = (q_wr == q_rd);
      r_empty = (r_wr == r_rd);

      q_head = q_mem[q_rd[PW-1:0]];
      r_head = r_mem[r_rd[PW-1:0]];

      out_valid = !q_empty && (!q_head.need_rsp || !r_empty);
      q_pop     = out_valid && out_ready;
      q_space   = !q_full || q_pop;

      // req only looks at the registered full flag so it cannot glitch with out_ready
      req = s_valid && s_mem && !f_ex && !flush && !q_full && (inflight < CW'(OUTSTANDING));
      accept = req && req_addr_ok;

      s_leave  = !flush && s_valid && ((s_mem && !f_ex) ? accept : q_space);
      in_ready = !s_valid || s_leave;
      s_take   = in_valid && in_ready && !flush;

      q_push = s_leave;
      q_in.need_rsp = s_mem && !f_ex;
      q_in.load     = s_load;
      q_in.size     = s_size;
      q_in.sign     = s_sign;
      q_in.off      = s_off;
      q_in.dest     = s_dest;
      q_in.data     = s_wdata;
      q_in.ex       = f_ex;
      q_in.exccode  = f_ex ? f_code : 5'd0;
      q_in.badvaddr = f_ex ? f_badv : 32'd0;

      drop     = rsp_data_ok && (ghost_cnt != '0);
      live_rsp = rsp_data_ok && (ghost_cnt == '0);
      r_push   = live_rsp && !flush;
      r_pop    = q_pop && q_head.need_rsp;

      inflight = live_cnt + ghost_cnt;

      // Request fields
      unique case (s_size)
         2'd0:    strb_base = STRB_W'(1);
         2'd1:    strb_base = STRB_W'(3);
         2'd2:    strb_base = STRB_W'(15);
         default: strb_base = '1;
      endcase
      req_wr    = s_store;
      req_size  = {1'b0, s_size};
      req_addr  = s_addr;
      req_wstrb = s_store ? (strb_base << s_off) : '0;
      req_wdata = s_wdata << {s_off, 3'b000};

      // Load data alignment and extension
      sh = r_head >> {q_head.off, 3'b000};
      unique case (q_head.size)
         2'd0: begin keep = DATA_W'(8'hFF);         sbit = sh[7];  end
         2'd1: begin keep = DATA_W'(16'hFFFF);      sbit = sh[15]; end
         2'd2: begin keep = DATA_W'(32'hFFFF_FFFF); sbit = sh[31]; end
         default: begin keep = '1;                  sbit = sh[DATA_W-1]; end
      endcase
      ext = (sh & keep) | ((q_head.sign && sbit) ? ~keep : '0);

      out_dest     = '0;
      out_data     = '0;
      out_ex       = 1'b0;
      out_exccode  = '0;
      out_badvaddr = '0;
      if (out_valid) begin
         out_dest     = q_head.dest;
         out_ex       = q_head.ex;
         out_exccode  = q_head.exccode;
         out_badvaddr = q_head.badvaddr;
         if (q_head.need_rsp) out_data = q_head.load ? ext : '0;
         else                 out_data = q_head.data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s_valid    <= 1'b0;
         s_load     <= 1'b0;
         s_store    <= 1'b0;
         s_size     <= '0;
         s_sign     <= 1'b0;
         s_addr     <= '0;
         s_wdata    <= '0;
         s_dest     <= '0;
         s_ex       <= 1'b0;
         s_exccode  <= '0;
         s_badvaddr <= '0;
      end else if (flush) begin
         s_valid <= 1'b0;
      end else if (s_take) begin
         s_valid    <= 1'b1;
         s_load     <= in_load;
         s_store    <= in_store;
         s_size     <= in_size;
         s_sign     <= in_sign;
         s_addr     <= in_addr;
         s_wdata    <= in_wdata;
         s_dest     <= in_dest;
         s_ex       <= in_ex;
         s_exccode  <= in_exccode;
         s_badvaddr <= in_badvaddr;
      end else if (s_leave) begin
         s_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         q_wr <= '0;
         q_rd <= '0;
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (q_push) q_wr <= q_wr + 1'b1;
         if (q_pop)  q_rd <= q_rd + 1'b1;
         if (r_push) r_wr <= r_wr + 1'b1;
         if (r_pop)  r_rd <= r_rd + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (q_push) q_mem[q_wr[PW-1:0]] <= q_in;
      if (r_push) r_mem[r_wr[PW-1:0]] <= rsp_rdata;
   end

   // On flush every live outstanding request (including one accepted this cycle) turns ghost
   always_ff @(posedge clk) begin
      if (reset) begin
         live_cnt  <= '0;
         ghost_cnt <= '0;
      end else if (flush) begin
         live_cnt  <= '0;
         ghost_cnt <= ghost_cnt - CW'(drop) + live_cnt + CW'(accept) - CW'(live_rsp);
      end else begin
         live_cnt  <= live_cnt + CW'(accept) - CW'(live_rsp);
         ghost_cnt <= ghost_cnt - CW'(drop);
      end
   end

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue: a vector table of single ops, plus hand-written sequences
// for back-pressure at OUTSTANDING and for ghost draining after a flush.
module tb_mem_req_queue;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, in_load, in_store, in_sign;
   logic [1:0]  in_size;
   logic [31:0] in_addr, in_wdata, in_badvaddr;
   logic [4:0]  in_dest, in_exccode;
   logic        in_ex;
   logic        req, req_wr, req_addr_ok, rsp_data_ok;
   logic [2:0]  req_size;
   logic [31:0] req_addr, req_wdata, rsp_rdata;
   logic [3:0]  req_wstrb;
   logic        out_valid, out_ready, out_ex;
   logic [4:0]  out_dest, out_exccode;
   logic [31:0] out_data, out_badvaddr;
   logic [2:0]  inflight;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_req_queue #(.DATA_W(32), .OUTSTANDING(4), .DEST_W(5)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
      .in_size(in_size), .in_sign(in_sign), .in_addr(in_addr), .in_wdata(in_wdata),
      .in_dest(in_dest), .in_ex(in_ex), .in_exccode(in_exccode), .in_badvaddr(in_badvaddr),
      .req(req), .req_wr(req_wr), .req_size(req_size), .req_addr(req_addr),
      .req_wstrb(req_wstrb), .req_wdata(req_wdata), .req_addr_ok(req_addr_ok),
      .rsp_data_ok(rsp_data_ok), .rsp_rdata(rsp_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_dest(out_dest), .out_data(out_data),
      .out_ex(out_ex), .out_exccode(out_exccode), .out_badvaddr(out_badvaddr),
      .inflight(inflight)
   );

   typedef struct {
      logic        load, store, sign;
      logic [1:0]  size;
      logic [31:0] addr, wdata, rdata;
      logic        ex_in;
      logic [4:0]  code_in;
      logic [31:0] badv_in;
      logic        e_req;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata;
      logic        e_ex;
      logic [4:0]  e_code;
      logic [31:0] e_badv, e_data;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic ld, input logic st, input logic [1:0] sz,
                               input logic sg, input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rd, input logic exi, input logic [4:0] ci,
                               input logic [31:0] bi, input logic er, input logic [3:0] es,
                               input logic [31:0] ew, input logic ee, input logic [4:0] ec,
                               input logic [31:0] eb, input logic [31:0] ed);
      vec_t v;
      v.load = ld; v.store = st; v.size = sz; v.sign = sg; v.addr = a; v.wdata = wd;
      v.rdata = rd; v.ex_in = exi; v.code_in = ci; v.badv_in = bi;
      v.e_req = er; v.e_strb = es; v.e_wdata = ew; v.e_ex = ee; v.e_code = ec;
      v.e_badv = eb; v.e_data = ed;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] lane_mask(input logic [3:0] s);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
      return m;
   endfunction

   task automatic drive_op(input logic ld, input logic st, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a, input logic [31:0] wd,
                           input logic [4:0] dst);
      in_valid = 1'b1; in_load = ld; in_store = st; in_size = sz; in_sign = sg;
      in_addr = a; in_wdata = wd; in_dest = dst; in_ex = 1'b0; in_exccode = '0;
      in_badvaddr = '0;
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd1);
      drive_op(v.load, v.store, v.size, v.sign, v.addr, v.wdata, 5'(i));
      in_ex = v.ex_in; in_exccode = v.code_in; in_badvaddr = v.badv_in;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d req", i), {31'd0, req}, {31'd0, v.e_req});
      if (v.e_req) begin
         chk($sformatf("v%0d req_wr", i), {31'd0, req_wr}, {31'd0, v.store});
         chk($sformatf("v%0d req_size", i), {29'd0, req_size}, {30'd0, v.size});
         chk($sformatf("v%0d req_addr", i), req_addr, v.addr);
         if (v.store) begin
            chk($sformatf("v%0d req_wstrb", i), {28'd0, req_wstrb}, {28'd0, v.e_strb});
            chk($sformatf("v%0d req_wdata", i), req_wdata & lane_mask(v.e_strb), v.e_wdata);
         end
         req_addr_ok = 1'b1;
         @(negedge clk);
         req_addr_ok = 1'b0;
         chk($sformatf("v%0d wait out_valid", i), {31'd0, out_valid}, 32'd0);
         chk($sformatf("v%0d inflight1", i), {29'd0, inflight}, 32'd1);
         rsp_data_ok = 1'b1; rsp_rdata = v.rdata;
         @(negedge clk);
         rsp_data_ok = 1'b0;
         chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd1);
         chk($sformatf("v%0d out_ex", i), {31'd0, out_ex}, 32'd0);
         chk($sformatf("v%0d inflight0", i), {29'd0, inflight}, 32'd0);
         if (v.load) chk($sformatf("v%0d out_data", i), out_data, v.e_data);
      end else begin
         @(negedge clk);
         chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd1);
         chk($sformatf("v%0d out_ex", i), {31'd0, out_ex}, {31'd0, v.e_ex});
         if (v.e_ex) begin
            chk($sformatf("v%0d exccode", i), {27'd0, out_exccode}, {27'd0, v.e_code});
            chk($sformatf("v%0d badvaddr", i), out_badvaddr, v.e_badv);
         end else begin
            chk($sformatf("v%0d out_data", i), out_data, v.e_data);
         end
      end
      chk($sformatf("v%0d out_dest", i), {27'd0, out_dest}, i);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] beats [5];
      bit got;
      //              ld st sz sg addr          wdata         rdata         ex code badv
      //              req strb ewdata          eex ecode badv          edata
      vecs[0]  = mk(1, 0, 2, 0, 32'h1004, 0, 32'h8000_00F0, 0, 0, 0,
                    1, 0, 0, 0, 0, 0, 32'h8000_00F0);
      vecs[1]  = mk(1, 0, 0, 1, 32'h1003, 0, 32'h8000_0000, 0, 0, 0,
                    1, 0, 0, 0, 0, 0, 32'hFFFF_FF80);
      vecs[2]  = mk(1, 0, 0, 0, 32'h1003, 0, 32'h8000_0000, 0, 0, 0,
                    1, 0, 0, 0, 0, 0, 32'h0000_0080);
      vecs[3]  = mk(1, 0, 1, 1, 32'h1002, 0, 32'h8001_1234, 0, 0, 0,
                    1, 0, 0, 0, 0, 0, 32'hFFFF_8001);
      vecs[4]  = mk(1, 0, 1, 0, 32'h1000, 0, 32'h1234_F00D, 0, 0, 0,
                    1, 0, 0, 0, 0, 0, 32'h0000_F00D);
      vecs[5]  = mk(1, 0, 0, 1, 32'h1001, 0, 32'h1122_A544, 0, 0, 0,
                    1, 0, 0, 0, 0, 0, 32'hFFFF_FFA5);
      vecs[6]  = mk(0, 1, 1, 0, 32'h2002, 32'h0000_BEEF, 0, 0, 0, 0,
                    1, 4'b1100, 32'hBEEF_0000, 0, 0, 0, 0);
      vecs[7]  = mk(0, 1, 0, 0, 32'h2001, 32'h0000_005A, 0, 0, 0, 0,
                    1, 4'b0010, 32'h0000_5A00, 0, 0, 0, 0);
      vecs[8]  = mk(0, 1, 2, 0, 32'h2000, 32'hDEAD_BEEF, 0, 0, 0, 0,
                    1, 4'b1111, 32'hDEAD_BEEF, 0, 0, 0, 0);
      vecs[9]  = mk(1, 0, 2, 0, 32'h1001, 0, 0, 0, 0, 0,
                    0, 0, 0, 1, 5'd4, 32'h1001, 0);
      vecs[10] = mk(0, 1, 2, 0, 32'h1001, 32'h55, 0, 0, 0, 0,
                    0, 0, 0, 1, 5'd5, 32'h1001, 0);
      vecs[11] = mk(1, 0, 1, 0, 32'h1003, 0, 0, 0, 0, 0,
                    0, 0, 0, 1, 5'd4, 32'h1003, 0);
      vecs[12] = mk(1, 0, 2, 0, 32'h0003, 0, 0, 1, 5'd8, 32'hABCD_0000,
                    0, 0, 0, 1, 5'd8, 32'hABCD_0000, 0);
      vecs[13] = mk(0, 0, 2, 0, 32'h0, 32'h1234_5678, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 32'h1234_5678);

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
      in_size = '0; in_sign = 1'b0; in_addr = '0; in_wdata = '0; in_dest = '0;
      in_ex = 1'b0; in_exccode = '0; in_badvaddr = '0; req_addr_ok = 1'b0;
      rsp_data_ok = 1'b0; rsp_rdata = '0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      chk("rst in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst req", {31'd0, req}, 32'd0);
      chk("rst out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst out_ex", {31'd0, out_ex}, 32'd0);
      chk("rst inflight", {29'd0, inflight}, 32'd0);
      chk("rst out_data", out_data, 32'd0);
      chk("rst req_addr", req_addr, 32'd0);
      chk("rst req_wstrb", {28'd0, req_wstrb}, 32'd0);

      for (int i = 0; i < NV; i++) run_vec(i);

      // Four loads back to back with no responses: the fifth must wait for a data beat
      beats[0] = 32'h11; beats[1] = 32'h22; beats[2] = 32'h33; beats[3] = 32'h44;
      beats[4] = 32'h55;
      @(negedge clk);
      req_addr_ok = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp in_ready%0d", k), {31'd0, in_ready}, 32'd1);
         drive_op(1, 0, 2, 0, 32'h100 + 32'(4 * k), 0, 5'(k));
         @(negedge clk);
      end
      in_valid = 1'b0; req_addr_ok = 1'b0;
      chk("bp inflight4", {29'd0, inflight}, 32'd4);
      chk("bp fifth req low", {31'd0, req}, 32'd0);
      rsp_data_ok = 1'b1; rsp_rdata = beats[0];
      @(negedge clk);
      rsp_data_ok = 1'b0;
      chk("bp first out", out_data, beats[0]);
      chk("bp inflight3", {29'd0, inflight}, 32'd3);
      got = 1'b0;
      for (int w = 0; w < 4 && !got; w++) begin
         if (req) got = 1'b1;
         else @(negedge clk);
      end
      chk("bp fifth req", {31'd0, req}, 32'd1);
      chk("bp fifth addr", req_addr, 32'h110);
      req_addr_ok = 1'b1;
      @(negedge clk);
      req_addr_ok = 1'b0;
      chk("bp inflight4b", {29'd0, inflight}, 32'd4);
      for (int k = 1; k < 5; k++) begin
         rsp_data_ok = 1'b1; rsp_rdata = beats[k];
         @(negedge clk);
         chk($sformatf("bp out%0d", k), out_valid ? out_data : 32'hX, beats[k]);
      end
      rsp_data_ok = 1'b0;
      @(negedge clk);
      chk("bp drained", {29'd0, inflight}, 32'd0);
      chk("bp out idle", {31'd0, out_valid}, 32'd0);

      // Two loads accepted, flush, then a new load; only the third beat reaches MEM
      drive_op(1, 0, 2, 0, 32'h200, 0, 5'd20);
      req_addr_ok = 1'b1;
      @(negedge clk);
      drive_op(1, 0, 2, 0, 32'h204, 0, 5'd21);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      req_addr_ok = 1'b0;
      chk("fl inflight2", {29'd0, inflight}, 32'd2);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("fl ghost2", {29'd0, inflight}, 32'd2);
      chk("fl out cleared", {31'd0, out_valid}, 32'd0);
      chk("fl in_ready", {31'd0, in_ready}, 32'd1);
      drive_op(1, 0, 2, 0, 32'h208, 0, 5'd22);
      req_addr_ok = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("fl new req", {31'd0, req}, 32'd1);
      @(negedge clk);
      req_addr_ok = 1'b0;
      chk("fl inflight3", {29'd0, inflight}, 32'd3);
      rsp_data_ok = 1'b1; rsp_rdata = 32'hAAAA;
      @(negedge clk);
      chk("fl drop1 inflight", {29'd0, inflight}, 32'd2);
      chk("fl drop1 out", {31'd0, out_valid}, 32'd0);
      rsp_rdata = 32'hBBBB;
      @(negedge clk);
      chk("fl drop2 inflight", {29'd0, inflight}, 32'd1);
      chk("fl drop2 out", {31'd0, out_valid}, 32'd0);
      rsp_rdata = 32'hCCCC;
      @(negedge clk);
      rsp_data_ok = 1'b0;
      chk("fl live out_valid", {31'd0, out_valid}, 32'd1);
      chk("fl live out_data", out_data, 32'hCCCC);
      chk("fl live out_dest", {27'd0, out_dest}, 32'd22);
      chk("fl inflight0", {29'd0, inflight}, 32'd0);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
